traffic_phase_controller: RTL and testbench

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

---
 rtl/traffic_phase_controller_if.sv | 22 ++
 rtl/traffic_phase_controller.sv | 131 +++++++++++++
 tb/tb_traffic_phase_controller.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_controller_if.sv
// Bundles the controller's sensor/strobe inputs and lamp/debug outputs.
// master drives the inputs (environment); slave is the controller itself.
interface traffic_phase_controller_if;
    logic       tick;
    logic       b_sense;
    logic       ped_req;
    logic       flash_en;
    logic [2:0] light_A;
    logic [2:0] light_B;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
        output tick, b_sense, ped_req, flash_en,
        input  light_A, light_B, ped_walk, phase
    );

    modport slave (
        input  tick, b_sense, ped_req, flash_en,
        output light_A, light_B, ped_walk, phase
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer: road A rests green, road B is served on
// demand (vehicle or pedestrian), with a flashing fault/night override.
module traffic_phase_controller #(
    parameter int CTR_W     = 8,
    parameter int T_GREEN_A = 7,
    parameter int T_GREEN_B = 7,
    parameter int T_YELLOW  = 2,
    parameter int T_ALLRED  = 2
) (
    input logic                        clk,
    input logic                        reset_n,
    traffic_phase_controller_if.slave  bus
);

    localparam logic [2:0] AG = 3'd0;
    localparam logic [2:0] AY = 3'd1;
    localparam logic [2:0] AR = 3'd2;
    localparam logic [2:0] BG = 3'd3;
    localparam logic [2:0] BY = 3'd4;
    localparam logic [2:0] BR = 3'd5;
    localparam logic [2:0] FL = 3'd6;

    localparam logic [CTR_W-1:0] LAST_GA = CTR_W'(T_GREEN_A - 1);
    localparam logic [CTR_W-1:0] LAST_GB = CTR_W'(T_GREEN_B - 1);
    localparam logic [CTR_W-1:0] LAST_Y  = CTR_W'(T_YELLOW - 1);
    localparam logic [CTR_W-1:0] LAST_R  = CTR_W'(T_ALLRED - 1);

    logic [2:0]       state, state_nxt;
    logic [CTR_W-1:0] ctr, ctr_nxt;
    logic             req_q;
    logic             blink, blink_nxt;
    logic [CTR_W-1:0] timed_last;
    logic [2:0]       timed_succ;

    // Dwell length and successor for the fixed-duration phases.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        timed_last = LAST_R;
        timed_succ = BR;
        case (state)
            AY:      begin timed_last = LAST_Y;  timed_succ = AR; end
            AR:      begin timed_last = LAST_R;  timed_succ = BG; end
            BG:      begin timed_last = LAST_GB; timed_succ = BY; end
            BY:      begin timed_last = LAST_Y;  timed_succ = BR; end
            BR:      begin timed_last = LAST_R;  timed_succ = AG; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        blink_nxt = 1'b1;
        if (bus.flash_en) begin
            // Flash override wins over tick and dwell; blink starts lit on entry.
            state_nxt = FL;
            ctr_nxt   = '0;
            blink_nxt = (state == FL) ? (blink ^ bus.tick) : 1'b1;
        end else begin
            case (state)
                AG: begin
                    if (bus.tick) begin
                        if (ctr != LAST_GA) begin
                            ctr_nxt = ctr + 1'b1;
                        end else if (req_q) begin
                            state_nxt = AY;
                            ctr_nxt   = '0;
                        end
                    end
                end
                AY, AR, BG, BY, BR: begin
                    if (bus.tick) begin
                        if (ctr == timed_last) begin
                            state_nxt = timed_succ;
                            ctr_nxt   = '0;
                        end else begin
                            ctr_nxt = ctr + 1'b1;
                        end
                    end
                end
                default: begin
                    // FL after release, and the unused code 7, both clear through all-red.
                    state_nxt = BR;
                    ctr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= AG;
            ctr   <= '0;
            req_q <= 1'b0;
            blink <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nxt;
            ctr   <= ctr_nxt;
            blink <= blink_nxt;
            // Serving road B consumes the pending demand; a still-held input re-arms it next cycle.
            if (state_nxt == BG && state != BG) begin
                req_q <= 1'b0;
            end else if (bus.b_sense || bus.ped_req) begin
                req_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.light_A  = 3'b100;
        bus.light_B  = 3'b100;
        bus.ped_walk = 1'b0;
        bus.phase    = state;
        case (state)
            AG: bus.light_A = 3'b001;
            AY: bus.light_A = 3'b010;
            BG: begin
                bus.light_B  = 3'b001;
                bus.ped_walk = 1'b1;
            end
            BY: bus.light_B = 3'b010;
            FL: begin
                bus.light_A = blink ? 3'b010 : 3'b000;
                bus.light_B = blink ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: each scenario queues the expected per-cycle outputs from the
// lamp table and phase durations, then pops and compares one entry per clock.
module tb_traffic_phase_controller;

    localparam logic [2:0] AG = 3'd0, AY = 3'd1, AR = 3'd2, BG = 3'd3,
                           BY = 3'd4, BR = 3'd5, FL = 3'd6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    traffic_phase_controller_if bus ();

    traffic_phase_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {phase, light_A, light_B, ped_walk}.
    wire [9:0] obs = {bus.phase, bus.light_A, bus.light_B, bus.ped_walk};

    logic [9:0] sb[$];

    function automatic logic [9:0] exp_of(input logic [2:0] ph, input logic bl);
        case (ph)
            AG:      return {ph, 3'b001, 3'b100, 1'b0};
            AY:      return {ph, 3'b010, 3'b100, 1'b0};
            AR:      return {ph, 3'b100, 3'b100, 1'b0};
            BG:      return {ph, 3'b100, 3'b001, 1'b1};
            BY:      return {ph, 3'b100, 3'b010, 1'b0};
            BR:      return {ph, 3'b100, 3'b100, 1'b0};
            FL:      return bl ? {ph, 3'b010, 3'b100, 1'b0} : {ph, 3'b000, 3'b000, 1'b0};
            default: return 10'h3ff;
        endcase
    endfunction

    task automatic push(input logic [2:0] ph, input int n);
        for (int i = 0; i < n; i++) sb.push_back(exp_of(ph, 1'b1));
    endtask

    // One full A->B->A service cycle, each dwell scaled by clocks per tick.
    task automatic push_cycle(input int m);
        push(AG, 7 * m); push(AY, 2 * m); push(AR, 2 * m);
        push(BG, 7 * m); push(BY, 2 * m); push(BR, 2 * m);
    endtask

    task automatic drive(input logic t, input logic bs, input logic pr, input logic fe);
        bus.tick     = t;
        bus.b_sense  = bs;
        bus.ped_req  = pr;
        bus.flash_en = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.tick = 1'b1; bus.b_sense = 1'b1; bus.ped_req = 1'b1; bus.flash_en = 1'b0;
        #2;
        checks++;
        if (obs !== exp_of(AG, 1'b1)) begin
            failures++;
            $display("FAIL reset_initial got=%h exp=%h", obs, exp_of(AG, 1'b1));
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_of(AG, 1'b1) || dut.req_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got=%h req_q=%b exp=%h req_q=0", obs, dut.req_q, exp_of(AG, 1'b1));
        end
    endtask

    task automatic test_sequence();
        int idx = 0;
        logic [9:0] e;
        do_reset();
        push_cycle(1);
        push(AG, 10);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL sequence idx=%0d got=%h exp=%h", idx, obs, e);
            end
            drive(1'b1, idx == 0, 1'b0, 1'b0);
            idx++;
        end
    endtask

    task automatic test_idle();
        int idx = 0;
        logic [9:0] e;
        do_reset();
        push(AG, 51);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL idle idx=%0d got=%h exp=%h", idx, obs, e);
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            idx++;
        end
    endtask

    task automatic test_ped();
        int idx = 0;
        logic [9:0] e;
        do_reset();
        push_cycle(1);
        push(AG, 12);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL ped idx=%0d got=%h exp=%h", idx, obs, e);
            end
            if (idx == 11) begin
                checks++;
                if (dut.req_q !== 1'b0) begin
                    failures++;
                    $display("FAIL ped_req_clear got=%b exp=0", dut.req_q);
                end
            end
            drive(1'b1, 1'b0, idx == 2, 1'b0);
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        logic [9:0] e;
        do_reset();
        push_cycle(1);
        push(AG, 7);
        push(AY, 2);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back idx=%0d got=%h exp=%h", idx, obs, e);
            end
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            idx++;
        end
    endtask

    task automatic test_flash();
        int idx = 0;
        logic [9:0] e;
        do_reset();
        push(AG, 7); push(AY, 2); push(AR, 2); push(BG, 4);
        for (int i = 0; i < 6; i++) sb.push_back(exp_of(FL, (i % 2) == 0));
        push(BR, 2);
        push(AG, 5);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL flash idx=%0d got=%h exp=%h", idx, obs, e);
            end
            drive(1'b1, idx == 0, 1'b0, idx >= 14 && idx <= 19);
            idx++;
        end
    endtask

    task automatic test_slow_tick();
        int idx = 0;
        logic [9:0] e;
        do_reset();
        push_cycle(4);
        push(AG, 8);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL slow_tick idx=%0d got=%h exp=%h", idx, obs, e);
            end
            drive((idx % 4) == 3, idx == 0, 1'b0, 1'b0);
            idx++;
        end
    endtask

    task automatic test_async_reset();
        int idx = 0;
        logic [9:0] e;
        do_reset();
        push(AG, 7); push(AY, 2); push(AR, 2); push(BG, 7); push(BY, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL async_pre idx=%0d got=%h exp=%h", idx, obs, e);
            end
            drive(1'b1, idx == 0, 1'b0, 1'b0);
            idx++;
        end
        checks++;
        if (obs !== exp_of(BY, 1'b1)) begin
            failures++;
            $display("FAIL async_in_by got=%h exp=%h", obs, exp_of(BY, 1'b1));
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== exp_of(AG, 1'b1)) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs, exp_of(AG, 1'b1));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.tick = 1'b0; bus.b_sense = 1'b0; bus.ped_req = 1'b0; bus.flash_en = 1'b0;
        test_reset();
        test_sequence();
        test_idle();
        test_ped();
        test_back_to_back();
        test_flash();
        test_slow_tick();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
